// File: rtl/key_history_display_if.sv
// Key/display bundle between the keypad front end and key_history_display.
// master drives the debounced key word; slave (the display block) drives the digit outputs.
interface key_history_display_if;
  logic [4:0] key_in;
  logic [3:0] sshow;
  logic       anode1_en;
  logic       anode2_en;
  logic       new_key;

  modport master (
    output key_in,
    input  sshow,
    input  anode1_en,
    input  anode2_en,
    input  new_key
  );

  modport slave (
    input  key_in,
    output sshow,
    output anode1_en,
    output anode2_en,
    output new_key
  );
endinterface

// File: rtl/key_history_display.sv
// Two-digit key history: one capture per key press, time-multiplexed onto a shared hex bus.
// Optional BLANK_UNUSED_EN keeps never-written digits dark.
module key_history_display #(
  parameter int unsigned REFRESH_DIV = 24000,
  parameter int unsigned DEAD_CYCLES = 16
) (
  input logic                   clk,
  input logic                   reset,
  key_history_display_if.slave  bus
);

  localparam int unsigned MaxDur = (REFRESH_DIV > DEAD_CYCLES) ? REFRESH_DIV : DEAD_CYCLES;
  localparam int unsigned CntW   = (MaxDur > 1) ? $clog2(MaxDur) : 1;

  typedef enum logic [1:0] {StShowNew, StGapA, StShowOld, StGapB} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              valid_q;
  logic [3:0]        digit_new_q, digit_old_q;
  logic [3:0]        shown_q;
  logic              new_key_q;
  logic              capture;
  logic              lit_new, lit_old;
  logic [3:0]        sshow_c;
  logic              anode1_c, anode2_c;
  int unsigned       dur;
  int unsigned       cnt_ext;

  // Rising edge of the valid bit; reset edges never capture.
  assign capture = bus.key_in[4] & ~valid_q & ~reset;

`ifdef BLANK_UNUSED_EN
  logic wr_new_q, wr_old_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_new_q <= 1'b0;
      wr_old_q <= 1'b0;
    end else if (capture) begin
      wr_new_q <= 1'b1;
      wr_old_q <= wr_new_q;
    end
  end

  assign lit_new = wr_new_q;
  assign lit_old = wr_old_q;
`else
  assign lit_new = 1'b1;
  assign lit_old = 1'b1;
`endif

  always_ff @(posedge clk) begin
    valid_q <= bus.key_in[4];
    if (reset) begin
      state_q     <= StShowNew;
      cnt_q       <= '0;
      digit_new_q <= 4'h0;
      digit_old_q <= 4'h0;
      shown_q     <= 4'h0;
      new_key_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      shown_q   <= sshow_c;
      new_key_q <= capture;
      if (capture) begin
        digit_old_q <= digit_new_q;
        digit_new_q <= bus.key_in[3:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    cnt_ext = 32'(cnt_q);
    dur     = (state_q == StShowNew || state_q == StShowOld) ? REFRESH_DIV : DEAD_CYCLES;
    // Gap states are unreachable when DEAD_CYCLES is 0, so dur-1 never underflows in use.
    if (cnt_ext == dur - 1) begin
      cnt_d = '0;
      unique case (state_q)
        StShowNew: state_d = (DEAD_CYCLES == 0) ? StShowOld : StGapA;
        StGapA:    state_d = StShowOld;
        StShowOld: state_d = (DEAD_CYCLES == 0) ? StShowNew : StGapB;
        StGapB:    state_d = StShowNew;
        default:   state_d = StShowNew;
      endcase
    end
  end

  always_comb begin
    anode1_c = 1'b1;
    anode2_c = 1'b1;
    sshow_c  = shown_q;
    unique case (state_q)
      StShowNew: begin
        anode1_c = ~lit_new;
        sshow_c  = digit_new_q;
      end
      StShowOld: begin
        anode2_c = ~lit_old;
        sshow_c  = digit_old_q;
      end
      default: ;
    endcase
  end

  assign bus.sshow     = sshow_c;
  assign bus.anode1_en = anode1_c;
  assign bus.anode2_en = anode2_c;
  assign bus.new_key   = new_key_q;

endmodule
